bus_slave_sel: RTL and testbench
================================

Name: bus_slave_sel

Overview:
- Registered, parametrised successor to the combinational address decoder.
- Decodes the master address MSBs into a one-hot slave chip-select and runs a per-transaction request/ready handshake.
- Muxes the selected slave's read data and ready back to the master.
- Issues a bus error for unmapped regions or for slaves that never answer (timeout).
- Sits between the CPU bus master and the ROM/SPM/timer/uart/gpio slaves.

Parameters:
- ADDR_WIDTH, 32, master address width.
- DATA_WIDTH, 32, read-data width.
- ADDR_IDX_WIDTH, 3, number of address MSBs used as the slave index.
- NUM_SLAVES, 8, number of chip-select outputs; must be <= 2**ADDR_IDX_WIDTH.
- SLAVE_MAP, 8'h1F, bit i = 1 means index i is mapped. Default maps ROM, SPM, timer, uart and gpio; indices 5-7 are unmapped.
- TIMEOUT_CYCLES, 255, cycles in ACCESS before a timeout error; must be >= 1.

Ports:
- clk_i  in  1  bus clock
- rst_n_i  in  1  asynchronous active-low reset
- m_req_i  in  1  master request; held high, with address stable, until m_rdy_o or m_err_o
- m_addr_i  in  ADDR_WIDTH  master address
- m_rdy_o  out  1  one-cycle transfer-complete pulse
- m_err_o  out  1  one-cycle bus-error pulse
- m_rdata_o  out  DATA_WIDTH  read data, valid while m_rdy_o is high
- s_cs_o  out  NUM_SLAVES  registered one-hot slave chip-select
- s_rdy_i  in  NUM_SLAVES  per-slave ready
- s_rdata_i  in  NUM_SLAVES*DATA_WIDTH  packed slave read data; slave i occupies bits [i*DATA_WIDTH +: DATA_WIDTH]
- err_addr_o  out  ADDR_WIDTH  last faulting address (optional feature)
- err_cnt_o  out  8  saturating error count (optional feature)

Behaviour:
- Reset (rst_n_i low, asynchronous):
  - state = IDLE.
  - s_cs_o, m_rdy_o, m_err_o, m_rdata_o, err_addr_o, err_cnt_o = 0.
  - Timeout counter = 0.
  - An in-flight transaction is dropped; no rdy or err pulse is produced for it.
- Index: idx = m_addr_i[ADDR_WIDTH-1 -: ADDR_IDX_WIDTH]. idx is mapped iff idx < NUM_SLAVES and SLAVE_MAP[idx] = 1.
- FSM states: IDLE, ACCESS, ERROR.
- IDLE:
  - On a clock edge with m_req_i = 1, latch idx.
  - If idx is mapped: go to ACCESS, set s_cs_o = 1 << idx, clear the counter.
  - If idx is unmapped: go to ERROR; s_cs_o stays 0.
- ACCESS:
  - s_cs_o is held. The counter increments every cycle.
  - If s_rdy_i[latched idx] = 1:
    - capture that slave's s_rdata_i into m_rdata_o;
    - m_rdy_o = 1 for the next cycle;
    - s_cs_o = 0;
    - go to IDLE.
  - Else if counter = TIMEOUT_CYCLES-1: go to ERROR and set s_cs_o = 0.
  - s_rdy_i bits of non-selected slaves are ignored.
  - Deasserting m_req_i in ACCESS does not abort the transaction.
- ERROR: m_err_o = 1 for exactly one cycle, then go to IDLE.
- Latency:
  - s_cs_o asserts 1 cycle after m_req_i is sampled.
  - m_rdy_o asserts 1 cycle after s_rdy_i is sampled.
  - Minimum transaction: 2 cycles from req sample to m_rdy_o high.
  - Unmapped error: m_err_o high 1 cycle after req sample.
- Simultaneous s_rdy_i and timeout on the same edge: ready wins, no error.
- Back-to-back: the master drops m_req_i in the cycle m_rdy_o or m_err_o is high. If m_req_i is still high in the cycle after return to IDLE, it starts a new transaction.
- m_rdata_o holds its last captured value outside m_rdy_o cycles.
- At most one s_cs_o bit is high at any time.

Optional Feature:
- Macro: BUS_ERR_CAPTURE_EN.
- Defined:
  - On every entry to ERROR, err_addr_o latches the faulting m_addr_i.
  - err_cnt_o increments and saturates at 8'hFF.
- Undefined: err_addr_o and err_cnt_o are tied to 0 and no capture registers are synthesised. Ports remain present.

Decomposition:
- Package bus_pkg:
  - state enum bus_sel_state_e {IDLE, ACCESS, ERROR};
  - default constants BUS_ADDR_W, BUS_DATA_W, BUS_IDX_W, BUS_NUM_SLAVES;
  - slave index constants ROM=0, SPM=1, TIMER=2, UART=3, GPIO=4;
  - default SLAVE_MAP.
- Sub-module bus_timeout_cnt:
  - inputs: clear, enable;
  - output: expired pulse, asserted when the count reaches TIMEOUT_CYCLES-1;
  - parametrised by TIMEOUT_CYCLES.

Test Plan:
- Reset mid-ACCESS: addr 0x2000_0000, slave 1 never ready, rst_n_i pulsed low in cycle 3 -> all outputs 0 immediately, state IDLE, no m_err_o afterwards.
- ROM read: addr 0x0000_0010, s_rdy_i[0] high in cycle 3 with data 0xDEAD_BEEF -> s_cs_o = 8'h01 from cycle 1; m_rdy_o pulses in cycle 4 with m_rdata_o = 0xDEAD_BEEF; s_cs_o = 0 in cycle 4.
- Unmapped access: addr 0xA000_0000 (idx 5) -> s_cs_o stays 0; m_err_o pulses 1 cycle after req. With BUS_ERR_CAPTURE_EN: err_addr_o = 0xA000_0000, err_cnt_o = 1.
- Timeout: TIMEOUT_CYCLES = 4, addr 0x6000_0000 (uart), no ready -> s_cs_o = 8'h08 for 4 cycles, then m_err_o pulse, m_rdy_o never asserted.
- Ready/timeout tie and foreign ready: TIMEOUT_CYCLES = 4, s_rdy_i[3] high on the 4th ACCESS cycle -> m_rdy_o, no m_err_o. s_rdy_i[2] high while uart is selected -> ignored.
- Back-to-back: timer read 0x4000_0000 then gpio read 0x8000_0004 with m_req_i held high -> s_cs_o sequence 8'h04, 0, 8'h10; two m_rdy_o pulses with the correct data each.

Source files
------------

// File: rtl/bus_pkg.sv
// Shared types and default constants for the registered bus slave selector.
package bus_pkg;

  localparam int BUS_ADDR_W     = 32;
  localparam int BUS_DATA_W     = 32;
  localparam int BUS_IDX_W      = 3;
  localparam int BUS_NUM_SLAVES = 8;

  localparam int ROM   = 0;
  localparam int SPM   = 1;
  localparam int TIMER = 2;
  localparam int UART  = 3;
  localparam int GPIO  = 4;

  // Indices above GPIO are left unmapped and return a bus error.
  localparam logic [BUS_NUM_SLAVES-1:0] BUS_SLAVE_MAP =
    BUS_NUM_SLAVES'((1 << ROM) | (1 << SPM) | (1 << TIMER) | (1 << UART) | (1 << GPIO));

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    ERROR  = 2'd2
  } bus_sel_state_e;

endpackage

// File: rtl/bus_timeout_cnt.sv
// Access watchdog: counts cycles while enabled and flags the last permitted cycle.
module bus_timeout_cnt #(
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic clk_i,
  input  logic rst_n_i,
  input  logic clear_i,
  input  logic enable_i,
  output logic expired_o
);

  localparam int CW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYCLES - 1);

  logic [CW-1:0] cnt_q, cnt_d;

  // Holding at LAST keeps the counter from wrapping if enable lingers.
  always_comb begin
    cnt_d = cnt_q;
    if (clear_i)
      cnt_d = '0;
    else if (enable_i && (cnt_q != LAST))
      cnt_d = cnt_q + 1'b1;
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

  assign expired_o = enable_i & (cnt_q == LAST);

endmodule

// File: rtl/bus_slave_sel.sv
// Registered address decoder with per-transaction handshake, read mux and timeout.
// Define BUS_ERR_CAPTURE_EN to record the last faulting address and an error count.
module bus_slave_sel
  import bus_pkg::*;
#(
  parameter int ADDR_WIDTH     = BUS_ADDR_W,
  parameter int DATA_WIDTH     = BUS_DATA_W,
  parameter int ADDR_IDX_WIDTH = BUS_IDX_W,
  parameter int NUM_SLAVES     = BUS_NUM_SLAVES,
  parameter logic [NUM_SLAVES-1:0] SLAVE_MAP = BUS_SLAVE_MAP,
  parameter int TIMEOUT_CYCLES = 255
) (
  input  logic                             clk_i,
  input  logic                             rst_n_i,
  input  logic                             m_req_i,
  input  logic [ADDR_WIDTH-1:0]            m_addr_i,
  output logic                             m_rdy_o,
  output logic                             m_err_o,
  output logic [DATA_WIDTH-1:0]            m_rdata_o,
  output logic [NUM_SLAVES-1:0]            s_cs_o,
  input  logic [NUM_SLAVES-1:0]            s_rdy_i,
  input  logic [NUM_SLAVES*DATA_WIDTH-1:0] s_rdata_i,
  output logic [ADDR_WIDTH-1:0]            err_addr_o,
  output logic [7:0]                       err_cnt_o
);

  localparam int NIDX = 1 << ADDR_IDX_WIDTH;

  bus_sel_state_e state_q, state_d;
  logic [NUM_SLAVES-1:0] cs_q, cs_d, dec;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d, sel_data;
  logic                  rdy_q, rdy_d, err_q, err_d;
  logic                  sel_rdy, expired;
  logic [ADDR_IDX_WIDTH-1:0] idx;
  logic [NIDX-1:0]           map_ext;

  assign idx = m_addr_i[ADDR_WIDTH-1 -: ADDR_IDX_WIDTH];

  // Indices beyond NUM_SLAVES have no chip-select and are always unmapped.
  for (genvar i = 0; i < NIDX; i++) begin : g_map
    if (i < NUM_SLAVES) begin : g_in
      assign map_ext[i] = SLAVE_MAP[i];
    end else begin : g_out
      assign map_ext[i] = 1'b0;
    end
  end

  always_comb begin
    dec = '0;
    for (int i = 0; i < NUM_SLAVES; i++)
      dec[i] = (idx == ADDR_IDX_WIDTH'(i));
  end

  // The registered one-hot chip-select doubles as the latched index.
  always_comb begin
    sel_rdy  = 1'b0;
    sel_data = '0;
    for (int i = 0; i < NUM_SLAVES; i++) begin
      if (cs_q[i]) begin
        sel_rdy  = sel_rdy | s_rdy_i[i];
        sel_data = sel_data | s_rdata_i[i*DATA_WIDTH +: DATA_WIDTH];
      end
    end
  end

  bus_timeout_cnt #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_tmo (
    .clk_i     (clk_i),
    .rst_n_i   (rst_n_i),
    .clear_i   (state_q != ACCESS),
    .enable_i  (state_q == ACCESS),
    .expired_o (expired)
  );

  always_comb begin
    state_d = state_q;
    cs_d    = cs_q;
    rdata_d = rdata_q;
    rdy_d   = 1'b0;
    err_d   = 1'b0;
    case (state_q)
      IDLE: begin
        if (m_req_i) begin
          if (map_ext[idx]) begin
            state_d = ACCESS;
            cs_d    = dec;
          end else begin
            state_d = ERROR;
            err_d   = 1'b1;
          end
        end
      end
      ACCESS: begin
        // Ready is checked first so it wins over a same-cycle timeout.
        if (sel_rdy) begin
          state_d = IDLE;
          cs_d    = '0;
          rdy_d   = 1'b1;
          rdata_d = sel_data;
        end else if (expired) begin
          state_d = ERROR;
          cs_d    = '0;
          err_d   = 1'b1;
        end
      end
      ERROR: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
        cs_d    = '0;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state_q <= IDLE;
      cs_q    <= '0;
      rdata_q <= '0;
      rdy_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cs_q    <= cs_d;
      rdata_q <= rdata_d;
      rdy_q   <= rdy_d;
      err_q   <= err_d;
    end
  end

  assign s_cs_o    = cs_q;
  assign m_rdy_o   = rdy_q;
  assign m_err_o   = err_q;
  assign m_rdata_o = rdata_q;

`ifdef BUS_ERR_CAPTURE_EN
  logic [ADDR_WIDTH-1:0] err_addr_q, err_addr_d;
  logic [7:0]            err_cnt_q, err_cnt_d;

  // err_d is high exactly on the edge that enters ERROR.
  always_comb begin
    err_addr_d = err_addr_q;
    err_cnt_d  = err_cnt_q;
    if (err_d) begin
      err_addr_d = m_addr_i;
      if (err_cnt_q != 8'hFF) err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      err_addr_q <= '0;
      err_cnt_q  <= '0;
    end else begin
      err_addr_q <= err_addr_d;
      err_cnt_q  <= err_cnt_d;
    end
  end

  assign err_addr_o = err_addr_q;
  assign err_cnt_o  = err_cnt_q;
`else
  logic unused_addr_lsbs;
  assign unused_addr_lsbs = ^m_addr_i[ADDR_WIDTH-ADDR_IDX_WIDTH-1:0];
  assign err_addr_o = '0;
  assign err_cnt_o  = '0;
`endif

endmodule

// File: tb/tb_bus_slave_sel.sv
// Bench for bus_slave_sel: directed protocol scenarios plus randomized transactions.
module tb_bus_slave_sel;

  localparam int AW = 32;
  localparam int DW = 32;
  localparam int NS = 8;
  localparam int TO = 4;
`ifdef BUS_ERR_CAPTURE_EN
  localparam bit CAP = 1'b1;
`else
  localparam bit CAP = 1'b0;
`endif

  logic               clk, rst_n, m_req, m_rdy, m_err;
  logic [AW-1:0]      m_addr, err_addr;
  logic [DW-1:0]      m_rdata;
  logic [NS-1:0]      s_cs, s_rdy;
  logic [NS*DW-1:0]   s_rdata;
  logic [7:0]         err_cnt;

  int checks = 0;
  int failures = 0;
  int exp_ecnt = 0;
  logic [AW-1:0] exp_eaddr = '0;

  bus_slave_sel #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i(clk), .rst_n_i(rst_n), .m_req_i(m_req), .m_addr_i(m_addr),
    .m_rdy_o(m_rdy), .m_err_o(m_err), .m_rdata_o(m_rdata), .s_cs_o(s_cs),
    .s_rdy_i(s_rdy), .s_rdata_i(s_rdata), .err_addr_o(err_addr), .err_cnt_o(err_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Drives one bus cycle's inputs just after the edge, returns at the sampling point.
  task automatic cyc(input logic req, input logic [AW-1:0] addr, input logic [NS-1:0] rdy);
    @(posedge clk);
    #1;
    m_req  = req;
    m_addr = addr;
    s_rdy  = rdy;
    @(negedge clk);
  endtask

  function automatic logic [7:0] exp_cnt_out();
    return CAP ? 8'(exp_ecnt) : 8'h00;
  endfunction

  function automatic logic [AW-1:0] exp_addr_out();
    return CAP ? exp_eaddr : '0;
  endfunction

  task automatic note_error(input logic [AW-1:0] addr);
    if (exp_ecnt < 255) exp_ecnt++;
    exp_eaddr = addr;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; m_req = 1'b0; m_addr = '0; s_rdy = '0;
    for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = $urandom;
    exp_ecnt = 0; exp_eaddr = '0;
    repeat (2) @(negedge clk);
    checks++;
    if ({s_cs, m_rdy, m_err, m_rdata, err_addr, err_cnt} !== '0) begin
      failures++;
      $display("FAIL reset_outputs cs=%h rdy=%b err=%b rdata=%h eaddr=%h ecnt=%h expected all zero",
               s_cs, m_rdy, m_err, m_rdata, err_addr, err_cnt);
    end
    rst_n = 1'b1;
  endtask

  task automatic test_rom_read();
    logic [AW-1:0] a = 32'h0000_0010;
    s_rdata[0 +: DW] = 32'hDEAD_BEEF;
    cyc(1'b1, a, '0);
    for (int c = 1; c <= 3; c++) begin
      cyc(1'b1, a, (c == 3) ? 8'h01 : 8'h00);
      checks++;
      if (s_cs !== 8'h01 || m_rdy !== 1'b0 || m_err !== 1'b0) begin
        failures++;
        $display("FAIL rom_access c%0d cs=%h rdy=%b err=%b expected cs=01 rdy=0 err=0", c, s_cs, m_rdy, m_err);
      end
    end
    cyc(1'b0, '0, '0);
    checks++;
    if (m_rdy !== 1'b1 || m_rdata !== 32'hDEAD_BEEF || s_cs !== 8'h00 || m_err !== 1'b0) begin
      failures++;
      $display("FAIL rom_done rdy=%b rdata=%h cs=%h err=%b expected rdy=1 rdata=deadbeef cs=00 err=0",
               m_rdy, m_rdata, s_cs, m_err);
    end
    cyc(1'b0, '0, '0);
    checks++;
    if (m_rdy !== 1'b0 || m_rdata !== 32'hDEAD_BEEF) begin
      failures++;
      $display("FAIL rom_hold rdy=%b rdata=%h expected rdy=0 rdata=deadbeef", m_rdy, m_rdata);
    end
  endtask

  task automatic test_reset_mid_access();
    logic [AW-1:0] a = 32'h2000_0000;
    cyc(1'b1, a, '0);
    cyc(1'b1, a, '0);
    checks++;
    if (s_cs !== 8'h02) begin
      failures++;
      $display("FAIL rstmid_cs got=%h expected=02", s_cs);
    end
    cyc(1'b1, a, '0);
    @(posedge clk);
    #2;
    rst_n = 1'b0; m_req = 1'b0; m_addr = '0;
    exp_ecnt = 0; exp_eaddr = '0;
    #1;
    checks++;
    if ({s_cs, m_rdy, m_err, m_rdata, err_addr, err_cnt} !== '0) begin
      failures++;
      $display("FAIL rstmid_async cs=%h rdy=%b err=%b rdata=%h eaddr=%h ecnt=%h expected all zero",
               s_cs, m_rdy, m_err, m_rdata, err_addr, err_cnt);
    end
    @(negedge clk);
    rst_n = 1'b1;
    for (int c = 0; c < 8; c++) begin
      cyc(1'b0, '0, '0);
      checks++;
      if (s_cs !== 8'h00 || m_err !== 1'b0 || m_rdy !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_quiet c%0d cs=%h err=%b rdy=%b expected 00/0/0", c, s_cs, m_err, m_rdy);
      end
    end
  endtask

  task automatic test_unmapped();
    logic [AW-1:0] a = 32'hA000_0000;
    cyc(1'b1, a, '0);
    cyc(1'b0, '0, '0);
    note_error(a);
    checks++;
    if (m_err !== 1'b1 || s_cs !== 8'h00 || m_rdy !== 1'b0) begin
      failures++;
      $display("FAIL unmapped_err err=%b cs=%h rdy=%b expected err=1 cs=00 rdy=0", m_err, s_cs, m_rdy);
    end
    checks++;
    if (err_addr !== exp_addr_out() || err_cnt !== exp_cnt_out()) begin
      failures++;
      $display("FAIL unmapped_capture eaddr=%h ecnt=%0d expected eaddr=%h ecnt=%0d",
               err_addr, err_cnt, exp_addr_out(), exp_cnt_out());
    end
    cyc(1'b0, '0, '0);
    checks++;
    if (m_err !== 1'b0) begin
      failures++;
      $display("FAIL unmapped_pulse err=%b expected=0", m_err);
    end
    // Drive the error counter past its saturation point.
    for (int n = 0; n < 260; n++) begin
      a = {3'(5 + (n % 3)), 29'($urandom)};
      cyc(1'b1, a, '0);
      cyc(1'b0, '0, '0);
      note_error(a);
    end
    checks++;
    if (err_cnt !== exp_cnt_out() || err_addr !== exp_addr_out()) begin
      failures++;
      $display("FAIL err_cnt_saturate ecnt=%0d eaddr=%h expected ecnt=%0d eaddr=%h",
               err_cnt, err_addr, exp_cnt_out(), exp_addr_out());
    end
  endtask

  task automatic test_timeout();
    logic [AW-1:0] a = 32'h6000_0000;
    cyc(1'b1, a, '0);
    for (int c = 1; c <= TO; c++) begin
      cyc(1'b1, a, '0);
      checks++;
      if (s_cs !== 8'h08 || m_err !== 1'b0 || m_rdy !== 1'b0) begin
        failures++;
        $display("FAIL timeout_access c%0d cs=%h err=%b rdy=%b expected cs=08 err=0 rdy=0", c, s_cs, m_err, m_rdy);
      end
    end
    cyc(1'b0, '0, '0);
    note_error(a);
    checks++;
    if (m_err !== 1'b1 || s_cs !== 8'h00 || m_rdy !== 1'b0 || err_addr !== exp_addr_out()) begin
      failures++;
      $display("FAIL timeout_err err=%b cs=%h rdy=%b eaddr=%h expected err=1 cs=00 rdy=0 eaddr=%h",
               m_err, s_cs, m_rdy, err_addr, exp_addr_out());
    end
    cyc(1'b0, '0, '0);
    checks++;
    if (m_err !== 1'b0 || m_rdy !== 1'b0) begin
      failures++;
      $display("FAIL timeout_after err=%b rdy=%b expected 0/0", m_err, m_rdy);
    end
  endtask

  task automatic test_tie_foreign();
    logic [AW-1:0] a = 32'h6000_0000;
    logic [DW-1:0] d3 = $urandom;
    s_rdata[3*DW +: DW] = d3;
    s_rdata[2*DW +: DW] = ~d3;
    cyc(1'b1, a, '0);
    for (int c = 1; c <= TO; c++) begin
      cyc(1'b1, a, (c == TO) ? 8'h0C : 8'h04);
      checks++;
      if (s_cs !== 8'h08 || m_rdy !== 1'b0 || m_err !== 1'b0) begin
        failures++;
        $display("FAIL tie_access c%0d cs=%h rdy=%b err=%b expected cs=08 rdy=0 err=0", c, s_cs, m_rdy, m_err);
      end
    end
    cyc(1'b0, '0, '0);
    checks++;
    if (m_rdy !== 1'b1 || m_err !== 1'b0 || m_rdata !== d3 || s_cs !== 8'h00) begin
      failures++;
      $display("FAIL tie_done rdy=%b err=%b rdata=%h cs=%h expected rdy=1 err=0 rdata=%h cs=00",
               m_rdy, m_err, m_rdata, s_cs, d3);
    end
    cyc(1'b0, '0, '0);
    checks++;
    if (m_err !== 1'b0) begin
      failures++;
      $display("FAIL tie_no_err err=%b expected=0", m_err);
    end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] d2 = $urandom;
    logic [DW-1:0] d4 = $urandom;
    s_rdata[2*DW +: DW] = d2;
    s_rdata[4*DW +: DW] = d4;
    cyc(1'b1, 32'h4000_0000, '0);
    cyc(1'b1, 32'h4000_0000, 8'h04);
    checks++;
    if (s_cs !== 8'h04) begin
      failures++;
      $display("FAIL b2b_cs_timer got=%h expected=04", s_cs);
    end
    cyc(1'b1, 32'h8000_0004, '0);
    checks++;
    if (m_rdy !== 1'b1 || m_rdata !== d2 || s_cs !== 8'h00) begin
      failures++;
      $display("FAIL b2b_timer_done rdy=%b rdata=%h cs=%h expected rdy=1 rdata=%h cs=00", m_rdy, m_rdata, s_cs, d2);
    end
    cyc(1'b1, 32'h8000_0004, 8'h10);
    checks++;
    if (s_cs !== 8'h10 || m_rdy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_cs_gpio cs=%h rdy=%b expected cs=10 rdy=0", s_cs, m_rdy);
    end
    cyc(1'b0, '0, '0);
    checks++;
    if (m_rdy !== 1'b1 || m_rdata !== d4 || s_cs !== 8'h00 || m_err !== 1'b0) begin
      failures++;
      $display("FAIL b2b_gpio_done rdy=%b rdata=%h cs=%h err=%b expected rdy=1 rdata=%h cs=00 err=0",
               m_rdy, m_rdata, s_cs, m_err, d4);
    end
    cyc(1'b0, '0, '0);
    checks++;
    if (s_cs !== 8'h00 || m_rdy !== 1'b0) begin
      failures++;
      $display("FAIL b2b_idle cs=%h rdy=%b expected 00/0", s_cs, m_rdy);
    end
  endtask

  // Each transaction's outcome follows from the spec rules: mapped slaves answer
  // if ready arrives within TO access cycles, otherwise the bus reports an error.
  task automatic test_random();
    for (int t = 0; t < 60; t++) begin
      int unsigned idx = $urandom_range(0, 7);
      int unsigned r = $urandom_range(1, TO + 2);
      logic [AW-1:0] a = {3'(idx), 29'($urandom)};
      bit mapped = ((8'h1F >> idx) & 8'h01) != 0;
      bit ok = mapped && (r <= TO);
      int n_acc = mapped ? ((r <= TO) ? int'(r) : TO) : 0;
      int end_c = n_acc + 1;
      logic [NS-1:0] sel = mapped ? NS'(1 << idx) : '0;
      logic [DW-1:0] exp_data;
      for (int i = 0; i < NS; i++) s_rdata[i*DW +: DW] = $urandom;
      exp_data = s_rdata[idx*DW +: DW];
      cyc(1'b1, a, '0);
      for (int c = 1; c <= end_c; c++) begin
        logic [NS-1:0] rdy = NS'($urandom) & ~sel;
        logic [NS-1:0] e_cs = (c <= n_acc) ? sel : '0;
        logic e_rdy = ok && (c == end_c);
        logic e_err = !ok && (c == end_c);
        if (mapped && c == int'(r)) rdy = rdy | sel;
        cyc(c < end_c, a, rdy);
        checks++;
        if (s_cs !== e_cs || m_rdy !== e_rdy || m_err !== e_err) begin
          failures++;
          $display("FAIL rand_t%0d_c%0d addr=%h cs=%h rdy=%b err=%b expected cs=%h rdy=%b err=%b",
                   t, c, a, s_cs, m_rdy, m_err, e_cs, e_rdy, e_err);
        end
        if (e_rdy) begin
          checks++;
          if (m_rdata !== exp_data) begin
            failures++;
            $display("FAIL rand_t%0d_rdata got=%h expected=%h", t, m_rdata, exp_data);
          end
        end
        if (e_err) begin
          note_error(a);
          checks++;
          if (err_addr !== exp_addr_out() || err_cnt !== exp_cnt_out()) begin
            failures++;
            $display("FAIL rand_t%0d_capture eaddr=%h ecnt=%0d expected eaddr=%h ecnt=%0d",
                     t, err_addr, err_cnt, exp_addr_out(), exp_cnt_out());
          end
        end
      end
      repeat ($urandom_range(0, 2)) begin
        cyc(1'b0, '0, NS'($urandom));
        checks++;
        if (s_cs !== '0 || m_rdy !== 1'b0 || m_err !== 1'b0) begin
          failures++;
          $display("FAIL rand_t%0d_gap cs=%h rdy=%b err=%b expected 00/0/0", t, s_cs, m_rdy, m_err);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_rom_read();
    test_reset_mid_access();
    test_unmapped();
    test_timeout();
    test_tie_foreign();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
